// File: rtl/mdu_alu_control_if.sv
// mdu_alu_control_if: decode inputs, operands and multiply/divide results between pipeline and MDU
interface mdu_alu_control_if #(parameter int WIDTH = 32);
  logic [1:0]       ALUOp;
  logic [5:0]       Funct;
  logic             valid;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [3:0]       alucontrol;
  logic             jr;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  modport master (output ALUOp, Funct, valid, rs_val, rt_val,
                  input alucontrol, jr, stall, hi, lo, div_by_zero);
  modport slave  (input ALUOp, Funct, valid, rs_val, rt_val,
                  output alucontrol, jr, stall, hi, lo, div_by_zero);
endinterface

// File: rtl/mdu_alu_control.sv
// mdu_alu_control: ALU control decode plus iterative radix-2 multiply/divide unit with HI/LO
module mdu_alu_control #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  mdu_alu_control_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
  localparam int CW = $clog2(WIDTH) + 1;
  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_a, r_hi, r_lo;
  logic               r_div, r_zero, r_neg, r_neg_r, r_dbz;
  logic [3:0]         w_alu;
  logic               w_start, w_signed, w_neg_s, w_neg_t;
  logic [WIDTH-1:0]   w_mag_s, w_mag_t, w_q, w_r;
  logic [WIDTH:0]     w_sum, w_up, w_diff;
  logic [2*WIDTH:0]   w_sh;
  logic [2*WIDTH-1:0] w_mul, w_dstep, w_prod;
  always_comb begin
    w_alu = 4'b1111;
    case (bus.ALUOp)
      2'b00: w_alu = 4'b0010;
      2'b01: w_alu = 4'b0110;
      2'b11: w_alu = 4'b0000;
      default:
        case (bus.Funct)
          6'd32, 6'd8, 6'd24, 6'd25, 6'd26, 6'd27: w_alu = 4'b0010;
          6'd34: w_alu = 4'b0110;
          6'd36: w_alu = 4'b0000;
          6'd37: w_alu = 4'b0001;
          6'd39: w_alu = 4'b1100;
          6'd42: w_alu = 4'b0111;
          6'd0:  w_alu = 4'b0011;
          6'd2:  w_alu = 4'b0100;
          6'd16: w_alu = 4'b1000;
          6'd18: w_alu = 4'b1001;
          default: w_alu = 4'b1111;
        endcase
    endcase
  end
  // Funct 24..27 share the pattern 0110xx: bit0 = unsigned, bit1 = divide
  assign w_start  = r_state == IDLE && bus.valid && bus.ALUOp == 2'b10 && bus.Funct[5:2] == 4'b0110;
  assign w_signed = ~bus.Funct[0];
  assign w_neg_s  = w_signed & bus.rs_val[WIDTH-1];
  assign w_neg_t  = w_signed & bus.rt_val[WIDTH-1];
  assign w_mag_s  = w_neg_s ? -bus.rs_val : bus.rs_val;
  assign w_mag_t  = w_neg_t ? -bus.rt_val : bus.rt_val;
  assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : '0);
  assign w_mul    = {w_sum, r_p[WIDTH-1:1]};
  // Restoring divide: remainder in the upper half, dividend shifts out as quotient shifts in
  assign w_sh     = {r_p, 1'b0};
  assign w_up     = w_sh[2*WIDTH:WIDTH];
  assign w_diff   = w_up - {1'b0, r_a};
  assign w_dstep  = w_diff[WIDTH] ? w_sh[2*WIDTH-1:0] : {w_diff[WIDTH-1:0], w_sh[WIDTH-1:1], 1'b1};
  assign w_prod   = r_neg ? -r_p : r_p;
  assign w_q      = r_zero ? '1 : (r_neg ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0]);
  assign w_r      = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_dbz <= r_state == FIX && r_div && r_zero;
      if (w_start) begin
        r_state <= RUN;
        r_cnt   <= '0;
        r_p     <= {{WIDTH{1'b0}}, w_mag_s};
        r_a     <= w_mag_t;
        r_div   <= bus.Funct[1];
        r_zero  <= bus.rt_val == '0;
        r_neg   <= w_neg_s ^ w_neg_t;
        r_neg_r <= w_neg_s;
      end else if (r_state == RUN) begin
        r_p   <= r_div ? w_dstep : w_mul;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
      end else if (r_state == FIX) begin
        r_hi    <= r_div ? w_r : w_prod[2*WIDTH-1:WIDTH];
        r_lo    <= r_div ? w_q : w_prod[WIDTH-1:0];
        r_cnt   <= '0;
        r_state <= IDLE;
      end
    end
  end
  assign bus.alucontrol  = w_alu;
  assign bus.jr          = bus.ALUOp == 2'b10 && bus.Funct == 6'd8;
  assign bus.stall       = r_state != IDLE;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_mdu_alu_control.sv
// tb_mdu_alu_control: directed self-checking bench for decode, multiply/divide, reset abort and WIDTH=8
module tb_mdu_alu_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mdu_alu_control_if #(.WIDTH(32)) b32();
  mdu_alu_control_if #(.WIDTH(8))  b8();
  mdu_alu_control #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
  mdu_alu_control #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));

  task automatic issue32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    b32.valid = 1'b1; b32.ALUOp = 2'b10; b32.Funct = f; b32.rs_val = a; b32.rt_val = b;
    @(posedge clk); #1;
    b32.valid = 1'b0;
  endtask

  task automatic wait32(output int cyc);
    cyc = 0;
    while (b32.stall && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (b32.stall !== 1'b0) begin errors++; $display("FAIL reset_stall32 got %b exp 0", b32.stall); end
    checks++; if (b32.hi !== 32'h0) begin errors++; $display("FAIL reset_hi32 got %h exp 0", b32.hi); end
    checks++; if (b32.lo !== 32'h0) begin errors++; $display("FAIL reset_lo32 got %h exp 0", b32.lo); end
    checks++; if (b32.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz32 got %b exp 0", b32.div_by_zero); end
    checks++; if (b8.stall !== 1'b0) begin errors++; $display("FAIL reset_stall8 got %b exp 0", b8.stall); end
    checks++; if (b8.hi !== 8'h0 || b8.lo !== 8'h0) begin errors++; $display("FAIL reset_hilo8 got %h/%h exp 00/00", b8.hi, b8.lo); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_decode;
    logic [12:0] tab [21];
    logic [12:0] e;
    tab = '{{2'd0,6'd0,4'h2,1'b0},  {2'd1,6'd0,4'h6,1'b0},  {2'd3,6'd0,4'h0,1'b0},
            {2'd0,6'd8,4'h2,1'b0},  {2'd2,6'd32,4'h2,1'b0}, {2'd2,6'd34,4'h6,1'b0},
            {2'd2,6'd36,4'h0,1'b0}, {2'd2,6'd37,4'h1,1'b0}, {2'd2,6'd39,4'hC,1'b0},
            {2'd2,6'd42,4'h7,1'b0}, {2'd2,6'd0,4'h3,1'b0},  {2'd2,6'd2,4'h4,1'b0},
            {2'd2,6'd16,4'h8,1'b0}, {2'd2,6'd18,4'h9,1'b0}, {2'd2,6'd8,4'h2,1'b1},
            {2'd2,6'd24,4'h2,1'b0}, {2'd2,6'd25,4'h2,1'b0}, {2'd2,6'd26,4'h2,1'b0},
            {2'd2,6'd27,4'h2,1'b0}, {2'd2,6'd63,4'hF,1'b0}, {2'd2,6'd1,4'hF,1'b0}};
    for (int i = 0; i < 21; i++) begin
      e = tab[i];
      @(negedge clk);
      b32.valid = 1'b0; b32.ALUOp = e[12:11]; b32.Funct = e[10:5];
      #1;
      checks++;
      if (b32.alucontrol !== e[4:1]) begin
        errors++; $display("FAIL decode_alu op=%0d funct=%0d got %b exp %b", e[12:11], e[10:5], b32.alucontrol, e[4:1]);
      end
      checks++;
      if (b32.jr !== e[0]) begin
        errors++; $display("FAIL decode_jr op=%0d funct=%0d got %b exp %b", e[12:11], e[10:5], b32.jr, e[0]);
      end
    end
    @(posedge clk); #1;
    checks++; if (b32.stall !== 1'b0) begin errors++; $display("FAIL decode_no_start got stall %b exp 0", b32.stall); end
  endtask

  task automatic test_mul_div;
    logic [5:0]  f  [10] = '{6'd24, 6'd25, 6'd26, 6'd27, 6'd26, 6'd27, 6'd26, 6'd24, 6'd26, 6'd25};
    logic [31:0] a  [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000,
                             32'd100, 32'd7, 32'hFFFFFFFB, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] b  [10] = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF,
                             32'd7, 32'hFFFFFFFE, 32'hFFFFFFFA, 32'd0, 32'd2};
    logic [31:0] eh [10] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7, 32'h0,
                             32'd2, 32'd1, 32'h0, 32'hFFFFFFF9, 32'h1};
    logic [31:0] el [10] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                             32'd14, 32'hFFFFFFFD, 32'h1E, 32'hFFFFFFFF, 32'h0};
    logic        ez [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int cyc;
    for (int i = 0; i < 10; i++) begin
      issue32(f[i], a[i], b[i]);
      wait32(cyc);
      checks++; if (cyc != 33) begin errors++; $display("FAIL op%0d_stall_cycles got %0d exp 33", i, cyc); end
      checks++; if (b32.hi !== eh[i]) begin errors++; $display("FAIL op%0d_hi got %h exp %h", i, b32.hi, eh[i]); end
      checks++; if (b32.lo !== el[i]) begin errors++; $display("FAIL op%0d_lo got %h exp %h", i, b32.lo, el[i]); end
      checks++; if (b32.div_by_zero !== ez[i]) begin errors++; $display("FAIL op%0d_dbz got %b exp %b", i, b32.div_by_zero, ez[i]); end
      @(posedge clk); #1;
      checks++; if (b32.div_by_zero !== 1'b0) begin errors++; $display("FAIL op%0d_dbz_pulse got %b exp 0", i, b32.div_by_zero); end
    end
  endtask

  task automatic test_abort;
    int cyc;
    int dbz_hits = 0;
    issue32(6'd27, 32'd7, 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (b32.stall !== 1'b0) begin errors++; $display("FAIL abort_stall got %b exp 0", b32.stall); end
    checks++; if (b32.hi !== 32'h0 || b32.lo !== 32'h0) begin errors++; $display("FAIL abort_hilo got %h/%h exp 0/0", b32.hi, b32.lo); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (b32.div_by_zero || b32.stall) dbz_hits++;
    end
    checks++; if (dbz_hits != 0) begin errors++; $display("FAIL abort_no_pulse got %0d active cycles exp 0", dbz_hits); end
    issue32(6'd25, 32'd6, 32'd7);
    wait32(cyc);
    checks++; if (cyc != 33) begin errors++; $display("FAIL abort_next_cycles got %0d exp 33", cyc); end
    checks++; if (b32.hi !== 32'h0 || b32.lo !== 32'd42) begin errors++; $display("FAIL abort_next_result got %h/%h exp 0/2a", b32.hi, b32.lo); end
  endtask

  task automatic test_reset_with_start;
    @(negedge clk);
    reset = 1'b1;
    b32.valid = 1'b1; b32.ALUOp = 2'b10; b32.Funct = 6'd24; b32.rs_val = 32'd3; b32.rt_val = 32'd4;
    @(posedge clk); #1;
    b32.valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    #1;
    checks++; if (b32.stall !== 1'b0) begin errors++; $display("FAIL rst_start_stall got %b exp 0", b32.stall); end
    checks++; if (b32.lo !== 32'h0) begin errors++; $display("FAIL rst_start_lo got %h exp 0", b32.lo); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue32(6'd24, 32'd3, 32'd4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    b32.valid = 1'b1; b32.Funct = 6'd24; b32.rs_val = 32'd100; b32.rt_val = 32'd100;
    for (int i = 0; i < 20; i++) @(posedge clk);
    #1;
    checks++; if (b32.lo !== 32'h0) begin errors++; $display("FAIL b2b_lo_hold got %h exp 0", b32.lo); end
    b32.valid = 1'b0;
    wait32(cyc);
    checks++; if (cyc + 23 != 33) begin errors++; $display("FAIL b2b_stall_cycles got %0d exp 33", cyc + 23); end
    checks++; if (b32.hi !== 32'h0 || b32.lo !== 32'd12) begin errors++; $display("FAIL b2b_result got %h/%h exp 0/c", b32.hi, b32.lo); end
    @(posedge clk); #1;
    checks++; if (b32.stall !== 1'b0) begin errors++; $display("FAIL b2b_second_ignored got stall %b exp 0", b32.stall); end
  endtask

  task automatic test_width8;
    logic [5:0] f  [3] = '{6'd26, 6'd24, 6'd27};
    logic [7:0] a  [3] = '{8'h80, 8'hFD, 8'hFF};
    logic [7:0] b  [3] = '{8'hFF, 8'h07, 8'h10};
    logic [7:0] eh [3] = '{8'h00, 8'hFF, 8'h0F};
    logic [7:0] el [3] = '{8'h80, 8'hEB, 8'h0F};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b8.valid = 1'b1; b8.ALUOp = 2'b10; b8.Funct = f[i]; b8.rs_val = a[i]; b8.rt_val = b[i];
      @(posedge clk); #1;
      b8.valid = 1'b0;
      cyc = 0;
      while (b8.stall && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      checks++; if (cyc != 9) begin errors++; $display("FAIL w8_op%0d_stall_cycles got %0d exp 9", i, cyc); end
      checks++; if (b8.hi !== eh[i]) begin errors++; $display("FAIL w8_op%0d_hi got %h exp %h", i, b8.hi, eh[i]); end
      checks++; if (b8.lo !== el[i]) begin errors++; $display("FAIL w8_op%0d_lo got %h exp %h", i, b8.lo, el[i]); end
    end
  endtask

  initial begin
    b32.valid = 1'b0; b32.ALUOp = 2'b00; b32.Funct = 6'd0; b32.rs_val = '0; b32.rt_val = '0;
    b8.valid = 1'b0;  b8.ALUOp = 2'b00;  b8.Funct = 6'd0;  b8.rs_val = '0;  b8.rt_val = '0;
    test_reset;
    test_decode;
    test_mul_div;
    test_abort;
    test_reset_with_start;
    test_back_to_back;
    test_width8;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_alu_control.md
MDU_ALU_CONTROL -- requirements
Module: mdu_alu_control

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/HI/LO datapath width (legal: 8..64).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port: ALUOp  input  2  main-control op class (00 add, 01 sub, 10 R-format, 11 and).
REQ-006 SHALL have port: Funct  input  6  R-format function field.
REQ-007 SHALL have port: valid  input  1  decoded instruction is real this cycle (not bubble).
REQ-008 SHALL have port: rs_val  input  WIDTH  first operand (multiplicand/dividend).
REQ-009 SHALL have port: rt_val  input  WIDTH  second operand (multiplier/divisor).
REQ-010 SHALL have port: alucontrol  output  4  ALU operation select (combinational).
REQ-011 SHALL have port: jr  output  1  jump-register indication (combinational).
REQ-012 SHALL have port: stall  output  1  multiply/divide unit busy; pipeline holds.
REQ-013 SHALL have port: hi  output  WIDTH  HI register (product high / remainder).
REQ-014 SHALL have port: lo  output  WIDTH  LO register (product low / quotient).
REQ-015 SHALL have port: div_by_zero  output  1  one-cycle pulse on completion of a divide with rt_val=0.

Function
REQ-016 SHALL decode alucontrol: ALUOp 00->0010, 01->0110, 11->0000; 10 by Funct: 32 add 0010, 34 sub 0110, 36 and 0000, 37 or 0001, 39 nor 1100, 42 slt 0111, 0 sll 0011, 2 srl 0100, 16 MFHI 1000, 18 MFLO 1001, 8/24/25/26/27 -> 0010, any other -> 1111.
REQ-017 SHALL drive jr = (ALUOp==10 && Funct==8), independent of valid and stall.
REQ-018 SHALL implement states IDLE, RUN, FIX; stall = (state != IDLE).
REQ-019 SHALL accept an op only when state==IDLE && valid && ALUOp==10 && Funct in {24 MULT, 25 MULTU, 26 DIV, 27 DIVU}; on that edge capture magnitudes (signed ops) or raw values (unsigned), op type, result-sign flags, iteration counter=0; go RUN.
REQ-020 SHALL, in RUN, perform one radix-2 iteration per cycle (shift-add multiply / restoring divide); after WIDTH RUN cycles go FIX.
REQ-021 SHALL, in FIX, apply two's-complement sign correction (signed ops), write hi/lo on that edge, go IDLE; stall therefore high exactly WIDTH+1 cycles; hi/lo change on edge WIDTH+1 after the capture edge.
REQ-022 SHALL compute MULT/MULTU: {hi,lo} = full 2*WIDTH-bit signed/unsigned product.
REQ-023 SHALL compute DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with sign of rs_val; DIV of most-negative by -1 yields lo=most-negative, hi=0.
REQ-024 SHALL, for divisor 0, keep full latency, write hi=rs_val, lo=all-ones, and pulse div_by_zero on the FIX edge.
REQ-025 SHALL ignore valid and all inputs except reset while stall is high; hi/lo hold while IDLE or RUN.
REQ-026 SHALL not internally forward: MFHI/MFLO issued while stall is high are held by the pipeline until stall falls.

Reset
REQ-027 SHALL on reset: state IDLE, counter 0, hi=0, lo=0, div_by_zero=0, stall=0 from the next cycle.
REQ-028 SHALL abort an in-flight operation on reset with no hi/lo write and no div_by_zero pulse.
REQ-029 SHALL treat reset with simultaneous start condition as reset only (op not accepted).

Verification (WIDTH=32 unless stated)
REQ-030 SHALL cover decode sweep: every ALUOp and listed Funct -> table of REQ-016; Funct=8 -> jr=1; Funct=63 -> 1111, jr=0.
REQ-031 SHALL cover MULT rs=0xFFFFFFFD rt=7 -> stall high 33 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFEB; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001.
REQ-032 SHALL cover DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi=7, lo=0xFFFFFFFF, div_by_zero high one cycle.
REQ-033 SHALL cover reset during RUN iteration 10 -> stall=0 next cycle, hi=lo=0; following MULTU 6*7 -> hi=0, lo=42.
REQ-034 SHALL cover second MULT asserted with valid while stall high -> ignored; hi/lo reflect first op only.
REQ-035 SHALL cover WIDTH=8 instance: DIV 0x80/0xFF -> lo=0x80, hi=0x00, stall high 9 cycles.
